// File: rtl/phaser_lfo_coeff.sv
// phaser_lfo_coeff: triangle LFO that produces one clamped signed Q4.12 allpass coefficient per sample.
// Rate/depth/centre are double-buffered and committed only when a sample computation starts.
module phaser_lfo_coeff #(
  parameter int PHASE_W  = 24,
  parameter int COEF_MAX = 4095
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_tick,
  input  logic               phase_sync,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_rate,
  input  logic [11:0]        cfg_depth,
  input  logic [15:0]        cfg_center,
  output logic [15:0]        coefficient,
  output logic               coeff_valid,
  output logic               overrun
);

  // Phase capture/advance happens on the edge that accepts the tick, so the
  // registered states name the remaining work: triangle, multiply, sum/clamp.
  typedef enum logic [1:0] {ST_IDLE, ST_TRI, ST_MUL, ST_SUM} state_t;

  function automatic logic signed [13:0] tri_bip(input logic [13:0] top);
    logic [12:0] seg;
    seg = top[13] ? ~top[12:0] : top[12:0];
    return $signed({1'b0, seg}) - 14'sd4096;
  endfunction

  function automatic logic signed [13:0] scale_depth(input logic signed [13:0] bip,
                                                     input logic [11:0]        depth);
    logic signed [26:0] prod;
    prod = 27'(bip) * 27'($signed({1'b0, depth}));
    return 14'(prod >>> 12);
  endfunction

  function automatic logic signed [15:0] sat_coef(input logic signed [17:0] s);
    logic signed [17:0] lim;
    lim = 18'(COEF_MAX);
    if (s > lim) return 16'(lim);
    else if (s < -lim) return 16'(-lim);
    return s[15:0];
  endfunction

  state_t                    state_q, state_d;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic [PHASE_W-1:0]        rate_q, rate_d;
  logic [11:0]               depth_q, depth_d;
  logic signed [15:0]        center_q, center_d;
  logic [PHASE_W-1:0]        sh_rate_q, sh_rate_d;
  logic [11:0]               sh_depth_q, sh_depth_d;
  logic [15:0]               sh_center_q, sh_center_d;
  logic                      pending_q, pending_d;
  logic signed [15:0]        coef_q, coef_d;
  logic                      cvld_q, cvld_d;
  logic                      ovr_q, ovr_d;
  logic [13:0]               ph_p1_q, ph_p1_d;
  logic signed [13:0]        bip_p2_q, bip_p2_d;
  logic signed [13:0]        mod_p3_q, mod_p3_d;
  logic                      tick_acc;
  logic                      cfg_fire;
  logic [PHASE_W-1:0]        inc_rate;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    rate_d      = rate_q;
    depth_d     = depth_q;
    center_d    = center_q;
    sh_rate_d   = sh_rate_q;
    sh_depth_d  = sh_depth_q;
    sh_center_d = sh_center_q;
    pending_d   = pending_q;
    coef_d      = coef_q;
    cvld_d      = 1'b0;
    ovr_d       = ovr_q;
    ph_p1_d     = ph_p1_q;
    bip_p2_d    = bip_p2_q;
    mod_p3_d    = mod_p3_q;
    inc_rate    = rate_q;
    cfg_fire    = cfg_valid && !pending_q;
    tick_acc    = sample_tick && (state_q == ST_IDLE);

    // A same-cycle transfer lands in the shadow only, so this tick still sees the old set.
    if (tick_acc && pending_q) begin
      rate_d    = sh_rate_q;
      depth_d   = sh_depth_q;
      center_d  = $signed(sh_center_q);
      inc_rate  = sh_rate_q;
      pending_d = 1'b0;
    end
    if (cfg_fire) begin
      sh_rate_d   = cfg_rate;
      sh_depth_d  = cfg_depth;
      sh_center_d = cfg_center;
      pending_d   = 1'b1;
    end
    if (sample_tick && (state_q != ST_IDLE)) ovr_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (tick_acc) begin
          ph_p1_d = phase_q[PHASE_W-1 -: 14];
          phase_d = phase_q + inc_rate;
          state_d = ST_TRI;
        end
      end
      ST_TRI: begin
        bip_p2_d = tri_bip(ph_p1_q);
        state_d  = ST_MUL;
      end
      ST_MUL: begin
        mod_p3_d = scale_depth(bip_p2_q, depth_q);
        state_d  = ST_SUM;
      end
      ST_SUM: begin
        coef_d  = sat_coef(18'(center_q) + 18'(mod_p3_q));
        cvld_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (phase_sync) phase_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      rate_q    <= '0;
      depth_q   <= '0;
      center_q  <= '0;
      pending_q <= 1'b0;
      coef_q    <= '0;
      cvld_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rate_q    <= rate_d;
      depth_q   <= depth_d;
      center_q  <= center_d;
      pending_q <= pending_d;
      coef_q    <= coef_d;
      cvld_q    <= cvld_d;
      ovr_q     <= ovr_d;
    end
  end

  // Shadow and pipeline data carry no reset; the FSM gates every use of them.
  always_ff @(posedge clk) begin
    sh_rate_q   <= sh_rate_d;
    sh_depth_q  <= sh_depth_d;
    sh_center_q <= sh_center_d;
    ph_p1_q     <= ph_p1_d;
    bip_p2_q    <= bip_p2_d;
    mod_p3_q    <= mod_p3_d;
  end

  assign cfg_ready   = ~pending_q;
  assign coefficient = coef_q;
  assign coeff_valid = cvld_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_phaser_lfo_coeff.sv
// Bench for phaser_lfo_coeff: directed steps drive a reference model whose expected
// coefficients and arrival cycles are queued and compared whenever coeff_valid pulses.
module tb_phaser_lfo_coeff;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        phase_sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_rate;
  logic [11:0] cfg_depth;
  logic [15:0] cfg_center;
  logic [15:0] coefficient;
  logic        coeff_valid;
  logic        overrun;

  phaser_lfo_coeff #(.PHASE_W(24), .COEF_MAX(4095)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .phase_sync  (phase_sync),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_rate    (cfg_rate),
    .cfg_depth   (cfg_depth),
    .cfg_center  (cfg_center),
    .coefficient (coefficient),
    .coeff_valid (coeff_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int expc_q[$];

  // reference model state
  logic [23:0] m_phase, m_rate, sh_r;
  logic [11:0] m_dep, sh_d;
  logic [15:0] m_cen, sh_c;
  bit          m_pend;
  int          busy_until;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_coef(input logic [23:0] ph, input logic [11:0] dep,
                                    input logic [15:0] cen);
    int top, t, bip, m, s;
    top = int'(ph >> 10);
    if (top >= 8192) t = 8191 - (top - 8192);
    else t = top;
    bip = t - 4096;
    m = bip * int'(dep);
    m = m >>> 12;
    s = int'($signed(cen)) + m;
    if (s > 4095) s = 4095;
    if (s < -4095) s = -4095;
    return s;
  endfunction

  always @(negedge clk) begin
    if (coeff_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        check("coef", int'($signed(coefficient)), exp_q.pop_front());
        check("latency", cyc, expc_q.pop_front());
      end
    end
  end

  // One clock of stimulus; called at a negedge, returns at the next negedge.
  task automatic drive(input logic tk, input logic cv, input logic ps,
                       input logic [23:0] r, input logic [11:0] d, input logic [15:0] c);
    bit          rdy, acc;
    logic [23:0] nph;
    rdy = !m_pend;
    acc = tk && (cyc >= busy_until);
    nph = m_phase;
    if (acc) begin
      if (m_pend) begin
        m_rate = sh_r; m_dep = sh_d; m_cen = sh_c; m_pend = 1'b0;
      end
      exp_q.push_back(model_coef(m_phase, m_dep, m_cen));
      expc_q.push_back(cyc + 4);
      nph = m_phase + m_rate;
      busy_until = cyc + 4;
    end
    if (cv && rdy) begin
      sh_r = r; sh_d = d; sh_c = c; m_pend = 1'b1;
    end
    if (ps) nph = '0;
    m_phase = nph;
    sample_tick = tk; cfg_valid = cv; phase_sync = ps;
    cfg_rate = r; cfg_depth = d; cfg_center = c;
    @(negedge clk);
    sample_tick = 1'b0; cfg_valid = 1'b0; phase_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic tick_gap(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      idle(7);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    m_phase = '0; m_rate = '0; m_dep = '0; m_cen = '0;
    m_pend = 1'b0; busy_until = 0;
    exp_q.delete(); expc_q.delete();
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    sample_tick = 1'b0; phase_sync = 1'b0; cfg_valid = 1'b0;
    cfg_rate = '0; cfg_depth = '0; cfg_center = '0;
    do_reset(2);
    check("rst_coef", int'($signed(coefficient)), 0);
    check("rst_valid", int'(coeff_valid), 0);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_overrun", int'(overrun), 0);

    // full-depth sweep around zero; one triangle period is 16 ticks
    drive(1'b0, 1'b1, 1'b0, 24'h100000, 12'd4095, 16'h0000);
    check("ready_after_cfg", int'(cfg_ready), 0);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("ready_after_apply", int'(cfg_ready), 1);
    idle(7);
    check("first_coef", int'($signed(coefficient)), -4095);
    tick_gap(8);
    check("peak_tick8", int'($signed(coefficient)), 4094);
    tick_gap(8);
    check("period_wrap", int'($signed(coefficient)), -4095);

    // zero depth leaves only the centre
    drive(1'b0, 1'b1, 1'b0, 24'h100000, 12'd0, 16'h0800);
    idle(2);
    tick_gap(4);
    check("depth0_center", int'($signed(coefficient)), 2048);

    // clamp at both rails
    drive(1'b0, 1'b1, 1'b1, 24'h800000, 12'd4095, 16'h0F00);
    idle(2);
    tick_gap(2);
    check("clamp_pos", int'($signed(coefficient)), 4095);
    drive(1'b0, 1'b1, 1'b0, 24'h800000, 12'd4095, 16'hF100);
    idle(2);
    tick_gap(1);
    check("clamp_neg", int'($signed(coefficient)), -4095);

    // config transfer coincident with a tick
    drive(1'b1, 1'b1, 1'b0, 24'h040000, 12'd4095, 16'h0000);
    idle(7);
    check("ready_held_low", int'(cfg_ready), 0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("ready_after_apply2", int'(cfg_ready), 1);
    idle(7);
    tick_gap(1);
    check("new_rate_used", int'($signed(coefficient)), -3840);

    // overrun: second tick two cycles later is dropped
    check("overrun_clear", int'(overrun), 0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    idle(7);
    check("overrun_set", int'(overrun), 1);
    tick_gap(1);
    check("overrun_sticky", int'(overrun), 1);

    // reset while the pipeline is in the multiply stage
    drive(1'b0, 1'b1, 1'b0, 24'h100000, 12'd2048, 16'h0100);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 24'h100000, 12'd2048, 16'h0100);
    do_reset(1);
    check("abort_coef", int'($signed(coefficient)), 0);
    check("abort_ready", int'(cfg_ready), 1);
    check("abort_valid", int'(coeff_valid), 0);
    check("abort_overrun", int'(overrun), 0);
    idle(6);

    // phase_sync, alone and coincident with a tick
    drive(1'b0, 1'b1, 1'b0, 24'h100000, 12'd2048, 16'h0100);
    idle(2);
    tick_gap(3);
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
    idle(2);
    tick_gap(1);
    check("sync_trough", int'($signed(coefficient)), -1792);
    drive(1'b1, 1'b0, 1'b1, '0, '0, '0);
    idle(7);
    tick_gap(1);
    check("sync_with_tick", int'($signed(coefficient)), -1792);

    idle(8);
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
